// File: rtl/spi_cmd_slave_rx_if.sv
// Bundle of SPI pins and the downstream frame handshake for spi_cmd_slave_rx.
interface spi_cmd_slave_rx_if #(
   parameter int CMD_BITS   = 41,
   parameter int REPLY_BITS = 6
);
   logic                  spi_clk;
   logic                  spi_cs;
   logic                  spi_mosi;
   logic                  spi_miso;
   logic [REPLY_BITS-1:0] status;
   logic [CMD_BITS-1:0]   data;
   logic [6:0]            data_num;
   logic                  dready;
   logic                  ack;
   logic [7:0]            drop_cnt;

   modport slave (
      input  spi_clk, spi_cs, spi_mosi, status, ack,
      output spi_miso, data, data_num, dready, drop_cnt
   );

   modport master (
      output spi_clk, spi_cs, spi_mosi, status, ack,
      input  spi_miso, data, data_num, dready, drop_cnt
   );
endinterface

// File: rtl/spi_cmd_slave_rx.sv
// SPI slave front end: oversampled majority-vote filtering of clk/cs, command
// frame capture, optional status reply on read opcode, dready/ack hand-off.
module spi_cmd_slave_rx #(
   parameter int                     CMD_BITS      = 41,
   parameter int                     REPLY_BITS    = 6,
   parameter int                     OPCODE_BITS   = 4,
   parameter logic [OPCODE_BITS-1:0] READ_OPCODE   = 4'b1000,
   parameter int                     OVS           = 5,
   parameter bit                     SAMPLE_RISING = 1'b1,
   parameter bit                     REPLY_INVERT  = 1'b1
) (
   input logic               clk,
   input logic               rst,
   spi_cmd_slave_rx_if.slave bus
);
   localparam int WW  = $clog2(OVS);
   localparam int SW  = $clog2(OVS + 1);
   localparam int RCW = $clog2(REPLY_BITS + 1);
   localparam logic [WW-1:0]  WIN_LAST = WW'(OVS - 1);
   localparam logic [SW:0]    HALF     = (SW + 1)'(OVS / 2);
   localparam logic [6:0]     CMD_N    = 7'(CMD_BITS);
   localparam logic [6:0]     OPC_LAST = 7'(OPCODE_BITS - 1);
   localparam logic [RCW-1:0] RC_LAST  = RCW'(REPLY_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [1:0]            sclk_q, sclk_d, scs_q, scs_d, smosi_q, smosi_d;
   logic [WW-1:0]         win_q, win_d;
   logic [SW-1:0]         clk_sum_q, clk_sum_d, cs_sum_q, cs_sum_d;
   logic                  clk_filt_q, clk_filt_d, cs_filt_q, cs_filt_d;
   logic                  clk_rise_q, clk_rise_d, clk_fall_q, clk_fall_d;
   logic                  cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
   logic                  cs_seen_q, cs_seen_d;
   state_t                state_q, state_d;
   logic [CMD_BITS-1:0]   data_q, data_d;
   logic [6:0]            num_q, num_d;
   logic                  dready_q, dready_d;
   logic [7:0]            drop_q, drop_d;
   logic                  miso_q, miso_d;
   logic                  armed_q, armed_d;
   logic [REPLY_BITS-1:0] rsr_q, rsr_d;
   logic [RCW-1:0]        rcnt_q, rcnt_d;
   logic                  opc_q, opc_d;

   logic [SW:0] clk_tot, cs_tot;
   logic        win_last, clk_hi, cs_hi, cap, lau;

   always_comb begin
      sclk_d  = {sclk_q[0], bus.spi_clk};
      scs_d   = {scs_q[0], bus.spi_cs};
      smosi_d = {smosi_q[0], bus.spi_mosi};

      // Window total includes the current sample, so each window spans OVS samples.
      win_last  = (win_q == WIN_LAST);
      clk_tot   = {1'b0, clk_sum_q} + {{SW{1'b0}}, sclk_q[1]};
      cs_tot    = {1'b0, cs_sum_q} + {{SW{1'b0}}, scs_q[1]};
      clk_hi    = (clk_tot > HALF);
      cs_hi     = (cs_tot > HALF);
      win_d     = win_last ? '0 : win_q + WW'(1);
      clk_sum_d = win_last ? '0 : clk_tot[SW-1:0];
      cs_sum_d  = win_last ? '0 : cs_tot[SW-1:0];
      clk_filt_d = win_last ? clk_hi : clk_filt_q;
      cs_filt_d  = win_last ? cs_hi : cs_filt_q;
      clk_rise_d = win_last & ~clk_filt_q & clk_hi;
      clk_fall_d = win_last & clk_filt_q & ~clk_hi;
      cs_rise_d  = win_last & ~cs_filt_q & cs_hi;
      // A cs fall only counts once cs has been seen idle high since reset,
      // so a frame interrupted by reset is never picked up half-way.
      cs_fall_d  = win_last & cs_filt_q & ~cs_hi & cs_seen_q;
      cs_seen_d  = cs_seen_q | (win_last & cs_hi);

      cap = SAMPLE_RISING ? clk_rise_q : clk_fall_q;
      lau = SAMPLE_RISING ? clk_fall_q : clk_rise_q;

      state_d  = state_q;
      data_d   = data_q;
      num_d    = num_q;
      dready_d = dready_q;
      drop_d   = drop_q;
      miso_d   = miso_q;
      armed_d  = armed_q;
      rsr_d    = rsr_q;
      rcnt_d   = rcnt_q;
      opc_d    = 1'b0;

      if (bus.ack) begin
         drop_d = '0;
         if (dready_q) begin
            dready_d = 1'b0;
            num_d    = '0;
         end
      end

      case (state_q)
         IDLE: begin
            if (cs_fall_q) begin
               if (dready_q) begin
                  state_d = DONE;
                  if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
               end else begin
                  state_d = SHIFT;
                  data_d  = '0;
                  num_d   = '0;
                  armed_d = 1'b0;
                  rsr_d   = '0;
                  rcnt_d  = '0;
                  miso_d  = 1'b0;
               end
            end
         end
         SHIFT: begin
            if (cap && num_q < CMD_N) begin
               data_d = {data_q[CMD_BITS-2:0], smosi_q[1]};
               num_d  = num_q + 7'd1;
               opc_d  = (num_q == OPC_LAST);
            end
            if (opc_q && data_q[OPCODE_BITS-1:0] == READ_OPCODE) begin
               rsr_d   = bus.status;
               armed_d = 1'b1;
               rcnt_d  = '0;
            end
            if (lau) begin
               if (armed_q) begin
                  miso_d = rsr_q[REPLY_BITS-1] ^ REPLY_INVERT;
                  rsr_d  = rsr_q << 1;
                  rcnt_d = rcnt_q + RCW'(1);
                  if (rcnt_q == RC_LAST) armed_d = 1'b0;
               end else begin
                  miso_d = 1'b0;
               end
            end
            if (cs_rise_q) begin
               state_d = IDLE;
               miso_d  = 1'b0;
               armed_d = 1'b0;
               if (num_d != '0) dready_d = 1'b1;
            end
         end
         DONE: begin
            if (cs_rise_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q     <= 2'b00;
         scs_q      <= 2'b11;
         smosi_q    <= 2'b00;
         win_q      <= '0;
         clk_sum_q  <= '0;
         cs_sum_q   <= '0;
         clk_filt_q <= 1'b1;
         cs_filt_q  <= 1'b1;
         clk_rise_q <= 1'b0;
         clk_fall_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
         cs_seen_q  <= 1'b0;
         state_q    <= IDLE;
         data_q     <= '0;
         num_q      <= '0;
         dready_q   <= 1'b0;
         drop_q     <= '0;
         miso_q     <= 1'b0;
         armed_q    <= 1'b0;
         rsr_q      <= '0;
         rcnt_q     <= '0;
         opc_q      <= 1'b0;
      end else begin
         sclk_q     <= sclk_d;
         scs_q      <= scs_d;
         smosi_q    <= smosi_d;
         win_q      <= win_d;
         clk_sum_q  <= clk_sum_d;
         cs_sum_q   <= cs_sum_d;
         clk_filt_q <= clk_filt_d;
         cs_filt_q  <= cs_filt_d;
         clk_rise_q <= clk_rise_d;
         clk_fall_q <= clk_fall_d;
         cs_rise_q  <= cs_rise_d;
         cs_fall_q  <= cs_fall_d;
         cs_seen_q  <= cs_seen_d;
         state_q    <= state_d;
         data_q     <= data_d;
         num_q      <= num_d;
         dready_q   <= dready_d;
         drop_q     <= drop_d;
         miso_q     <= miso_d;
         armed_q    <= armed_d;
         rsr_q      <= rsr_d;
         rcnt_q     <= rcnt_d;
         opc_q      <= opc_d;
      end
   end

   assign bus.spi_miso = miso_q;
   assign bus.data     = data_q;
   assign bus.data_num = num_q;
   assign bus.dready   = dready_q;
   assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_spi_cmd_slave_rx.sv
// Directed + randomized frames against a frame-level reference model.
module tb_spi_cmd_slave_rx;
   localparam int CMD = 41;
   localparam int REP = 6;
   localparam int OPC = 4;
   localparam logic [127:0] RD_OP = 128'h8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_cmd_slave_rx_if #(.CMD_BITS(CMD), .REPLY_BITS(REP)) bus ();

   spi_cmd_slave_rx #(
      .CMD_BITS(CMD), .REPLY_BITS(REP), .OPCODE_BITS(OPC), .READ_OPCODE(4'b1000),
      .OVS(5), .SAMPLE_RISING(1'b1), .REPLY_INVERT(1'b1)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   logic miso_s [0:127];

   initial begin
      #5000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Half-period 12 clk; mosi changes mid-low; optional 1-2 clk glitches at bit 5.
   task automatic send(input logic [127:0] v, input int n, input bit glitch);
      int g;
      bus.spi_cs = 1'b0;
      cyc(14);
      for (int i = 0; i < n; i++) begin
         g = $urandom_range(1, 2);
         cyc(4);
         if (glitch && i == 5) begin
            bus.spi_clk = 1'b1; bus.spi_cs = 1'b1;
            cyc(g);
            bus.spi_clk = 1'b0; bus.spi_cs = 1'b0;
            cyc(2 - g);
         end else cyc(2);
         bus.spi_mosi = v[n-1-i];
         cyc(6);
         bus.spi_clk = 1'b1;
         cyc(6);
         if (glitch && i == 5) begin
            bus.spi_clk = 1'b0;
            cyc(g);
            bus.spi_clk = 1'b1;
            cyc(6 - g);
         end else cyc(6);
         miso_s[i] = bus.spi_miso;
         bus.spi_clk = 1'b0;
      end
      cyc(14);
      miso_s[n] = bus.spi_miso;
      bus.spi_cs = 1'b1;
      cyc(24);
   endtask

   function automatic int exp_num(input int n);
      return (n < CMD) ? n : CMD;
   endfunction

   function automatic logic [127:0] exp_data(input logic [127:0] v, input int n);
      int k;
      k = exp_num(n);
      return (v >> (n - k)) & ((128'b1 << k) - 128'b1);
   endfunction

   // Reply bit visible on miso after the j-th launch edge.
   function automatic logic exp_miso(input logic [127:0] v, input int n,
                                     input logic [REP-1:0] st, input int j);
      logic match;
      match = (n >= OPC) && (((v >> (n - OPC)) & 128'hF) == RD_OP);
      if (match && j >= OPC && j < OPC + REP) return ~st[REP-1-(j-OPC)];
      return 1'b0;
   endfunction

   task automatic check_frame(input string tag, input logic [127:0] v, input int n,
                              input logic [REP-1:0] st);
      chk({tag, ".dready"}, 128'(bus.dready), 128'd1);
      chk({tag, ".data"}, 128'(bus.data), exp_data(v, n));
      chk({tag, ".num"}, 128'(bus.data_num), 128'(exp_num(n)));
      chk({tag, ".drop"}, 128'(bus.drop_cnt), 128'd0);
      for (int j = 0; j <= n; j++)
         chk($sformatf("%s.miso%0d", tag, j), 128'(miso_s[j]), 128'(exp_miso(v, n, st, j)));
   endtask

   task automatic do_ack(input string tag, input logic [127:0] held);
      bus.ack = 1'b1;
      cyc(1);
      bus.ack = 1'b0;
      cyc(1);
      chk({tag, ".ack_dready"}, 128'(bus.dready), 128'd0);
      chk({tag, ".ack_num"}, 128'(bus.data_num), 128'd0);
      chk({tag, ".ack_data_held"}, 128'(bus.data), held);
   endtask

   task automatic frame(input string tag, input logic [127:0] v, input int n, input bit glitch);
      logic [REP-1:0] st;
      st = REP'($urandom);
      bus.status = st;
      send(v, n, glitch);
      check_frame(tag, v, n, st);
      do_ack(tag, exp_data(v, n));
   endtask

   initial begin
      logic [127:0] v, va;
      int n;
      rst = 1'b1;
      bus.spi_clk = 1'b0; bus.spi_cs = 1'b1; bus.spi_mosi = 1'b0;
      bus.ack = 1'b0; bus.status = '0;
      cyc(5);
      chk("rst.miso", 128'(bus.spi_miso), 128'd0);
      chk("rst.data", 128'(bus.data), 128'd0);
      chk("rst.num", 128'(bus.data_num), 128'd0);
      chk("rst.dready", 128'(bus.dready), 128'd0);
      chk("rst.drop", 128'(bus.drop_cnt), 128'd0);
      rst = 1'b0;
      cyc(20);

      // 41-bit default frame
      v = 128'h123456789A;
      bus.status = 6'b101100;
      send(v, 41, 1'b0);
      chk("fix.data_const", 128'(bus.data), 128'h123456789A);
      check_frame("fix", v, 41, 6'b101100);
      do_ack("fix", 128'h123456789A);

      // read opcode with status reply, inverted: 0,1,0,0,1,1 then 0
      v = (128'b1000 << 7) | 128'($urandom_range(0, 127));
      bus.status = 6'b101100;
      send(v, 11, 1'b0);
      chk("rd.seq", 128'({miso_s[4], miso_s[5], miso_s[6], miso_s[7], miso_s[8], miso_s[9], miso_s[10]}),
          128'b0100110);
      check_frame("rd", v, 11, 6'b101100);
      do_ack("rd", exp_data(v, 11));

      // non-read opcode: no reply
      n = $urandom_range(8, 20);
      v = 128'({$urandom, $urandom});
      v[n-1 -: 4] = 4'b1001;
      frame("op1001", v, n, 1'b0);

      // overlength frame: trailing bits ignored
      v = 128'({$urandom, $urandom});
      frame("long50", v, 50, 1'b0);

      // glitches on spi_clk and spi_cs mid-frame
      v = 128'({$urandom, $urandom});
      v[29 -: 4] = 4'b1000;
      frame("glitch", v, 30, 1'b1);

      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 48);
         v = 128'({$urandom, $urandom});
         if (n >= OPC && $urandom_range(0, 1) == 1) v[n-1 -: 4] = 4'b1000;
         frame($sformatf("rnd%0d", r), v, n, 1'b0);
      end

      // second frame before ack is dropped
      va = 128'({$urandom, $urandom});
      bus.status = '0;
      send(va, 20, 1'b0);
      chk("drop.first_dready", 128'(bus.dready), 128'd1);
      v = 128'({$urandom, $urandom});
      send(v, 16, 1'b0);
      chk("drop.cnt", 128'(bus.drop_cnt), 128'd1);
      chk("drop.data", 128'(bus.data), exp_data(va, 20));
      chk("drop.num", 128'(bus.data_num), 128'd20);
      chk("drop.dready", 128'(bus.dready), 128'd1);
      do_ack("drop", exp_data(va, 20));
      chk("drop.cnt_clr", 128'(bus.drop_cnt), 128'd0);

      // reset mid-frame, remainder of that frame must be ignored
      bus.spi_cs = 1'b0;
      cyc(14);
      for (int i = 0; i < 7; i++) begin
         if (i == 3) begin rst = 1'b1; cyc(3); rst = 1'b0; end
         bus.spi_mosi = i[0];
         cyc(12); bus.spi_clk = 1'b1;
         cyc(12); bus.spi_clk = 1'b0;
      end
      cyc(14);
      bus.spi_cs = 1'b1;
      cyc(30);
      chk("rstmid.dready", 128'(bus.dready), 128'd0);
      chk("rstmid.num", 128'(bus.data_num), 128'd0);
      v = 128'({$urandom, $urandom});
      frame("fresh", v, 33, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_cmd_slave_rx.md
# spi_cmd_slave_rx

Parametrised SPI slave front end between the host-side SPI link and the board control logic. It oversamples SPI clock and chip-select on the system clock with majority-vote filtering, shifts in a command frame of up to CMD_BITS bits, and, when a configurable read opcode arrives, streams a status word back on MISO in the same frame. Completed frames go to the downstream command decoder through a dready/ack handshake. Frames that arrive while a completed frame is still unacknowledged are counted as drops.

## Interface
- CMD_BITS, 41: maximum command frame length in bits (2..127).
- REPLY_BITS, 6: status reply length in bits (1..CMD_BITS).
- OPCODE_BITS, 4: number of leading bits compared against READ_OPCODE.
- READ_OPCODE, 4'b1000: opcode that triggers a status reply.
- OVS, 5: samples per majority-vote window (odd, 3..15).
- SAMPLE_RISING, 1: 1 = capture MOSI on the filtered rising edge and launch MISO on the falling edge; 0 = the reverse.
- REPLY_INVERT, 1: 1 = drive the complement of each status bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- spi_clk  in  1  SPI clock, asynchronous to clk.
- spi_cs  in  1  chip select, active-low, asynchronous to clk.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial reply, MSB first.
- status  in  REPLY_BITS  live status word (e.g. PLL locks), captured at opcode match.
- data  out  CMD_BITS  received bits, right-aligned; the last bit received is at data[0].
- data_num  out  7  number of bits captured in the frame.
- dready  out  1  completed frame available.
- ack  in  1  consumer acknowledge.
- drop_cnt  out  8  frames discarded while dready=1. Saturates at 255 and is cleared by ack.

## Operation
- Input conditioning:
  - spi_clk, spi_cs and spi_mosi pass through 2-flop synchronisers.
  - One window counter counts 0..OVS-1. Each window sums the synchronised clk and cs samples.
  - At window end, filtered level = 1 if sum > OVS/2 (integer division), else 0. The sums then clear.
  - Filtered levels reset to 1. A filtered edge is a change in filtered level between windows.
- Receive state machine, states IDLE, SHIFT, DONE:
  - IDLE: on a filtered cs fall, go to SHIFT if dready=0. Clear data_num, data and the reply logic. If dready=1, go to DONE without capturing and increment drop_cnt (saturating).
  - SHIFT, on each capture edge: if data_num < CMD_BITS, shift data left with the synchronised mosi into data[0] and increment data_num. Otherwise ignore the bit; data_num saturates at CMD_BITS.
  - SHIFT, opcode check: the cycle data_num becomes OPCODE_BITS, compare data[OPCODE_BITS-1:0] with READ_OPCODE. On a match, load status into the reply shift register and arm the reply.
  - SHIFT, on a filtered cs rise: if data_num ≠ 0, set dready. Return to IDLE.
  - DONE (dropped frame): ignore all edges and return to IDLE on a filtered cs rise.
- Reply:
  - While armed, on each launch edge, drive spi_miso with the reply MSB (complemented if REPLY_INVERT=1), shift left and count.
  - After REPLY_BITS launches, disarm and hold spi_miso at 0.
  - spi_miso is 0 outside an armed reply and forced to 0 on a cs rise.
- Handshake:
  - dready holds until ack=1 is sampled; then dready, data_num and drop_cnt clear in the same cycle.
  - data is held until the next accepted frame starts.
  - ack while dready=0 has no effect except clearing drop_cnt.
  - If ack and an accepted-frame end fall in the same cycle, the new completion wins: dready stays 1.
- Reset values: spi_miso 0, data 0, data_num 0, dready 0, drop_cnt 0; state IDLE, filtered levels 1.
- Asserting rst mid-frame aborts the frame. After release, the receiver waits for a new filtered cs fall; a frame in progress is not resumed.

## Timing
- Filter latency from a pin change to the filtered edge: 2 sync cycles plus up to 2·OVS cycles.
- Requirements on the SPI master:
  - Each SPI clock half-period is at least 2·OVS clk cycles.
  - cs setup to the first edge is at least 2·OVS cycles.
  - cs hold after the last edge is at least 2·OVS cycles.
- A bit is captured on the clk cycle after the filtered capture edge is detected. MOSI is sampled from the synchroniser output at that cycle.
- The opcode comparison completes one cycle after the OPCODE_BITS-th capture.
- The first MISO bit appears on the first launch edge following the match.
- spi_miso updates one cycle after the filtered launch edge. The master sees it roughly 2·OVS+3 cycles after its own edge.
- dready rises one cycle after the filtered cs rise.
- All logic is on the clk rising edge only.

## Test plan
- Defaults, 41-bit frame 0x1_2345_6789A with OVS=5 and half-period 12 clk: data=0x123456789A, data_num=41, dready=1. After ack, dready=0 and data_num=0.
- Opcode 1000 followed by 6 clocks, status=6'b101100, REPLY_INVERT=1: MISO sequence 0,1,0,0,1,1 on successive launch edges, then 0.
- Opcode 1001: no reply, MISO stays 0 for the whole frame; data_num equals the clocked bit count.
- 50-bit frame with CMD_BITS=41: data_num=41, data holds the first 41 bits, and the trailing 9 bits are ignored.
- Single-sample glitches of 1–2 clk on spi_clk and spi_cs (OVS=5) mid-frame: no extra captures, frame unchanged.
- Second frame sent before ack: drop_cnt=1 and data unchanged. Assert rst mid-frame, then send a fresh frame: it is received correctly with drop_cnt=0.
